// File: rtl/ring_pkg.sv
// ring_pkg: constants shared by Beehive ring clients and the coherent memory
// mux. Holds the slot-type encodings, the Address-slot payload layout and the
// ring-station state enum.
package ring_pkg;

  localparam logic [3:0] SLOT_TOKEN = 4'd1;
  localparam logic [3:0] SLOT_ADDR  = 4'd2;
  localparam logic [3:0] SLOT_WDATA = 4'd3;
  localparam logic [3:0] SLOT_NULL  = 4'd7;

  localparam int READ_BIT = 28;
  localparam int ADDR_MSB = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WDATA = 2'd2,
    ST_RETOK = 2'd3
  } station_state_e;

  // Address slot payload: read flag at READ_BIT, line address in the low bits,
  // every other bit zero.
  function automatic logic [31:0] addr_payload(input logic rd, input logic [ADDR_MSB:0] addr);
    logic [31:0] p;
    p              = '0;
    p[READ_BIT]    = rd;
    p[ADDR_MSB:0]  = addr;
    return p;
  endfunction

endpackage

// File: rtl/rd_line_assembler.sv
// rd_line_assembler: collects four 32-bit read-return beats into one 128-bit
// line.
//   clock, reset   ring clock, synchronous active-high reset
//   beat_vld       a beat addressed to this station is on beat_data
//   beat_data      32-bit beat; beat k lands in rd_data[32k+31:32k]
//   done           combinational: the current beat completes the line
//   rd_valid       one-cycle pulse the cycle after done
//   rd_data        line register (reset value 0)
module rd_line_assembler
  import ring_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         beat_vld,
  input  logic [31:0]  beat_data,
  output logic         done,
  output logic         rd_valid,
  output logic [127:0] rd_data
);

  logic [1:0]   cnt_q,   cnt_d;
  logic [127:0] line_q,  line_d;
  logic         valid_q, valid_d;

  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    done   = beat_vld & (cnt_q == 2'd3);
    if (beat_vld) begin
      line_d[{cnt_q, 5'b0} +: 32] = beat_data;
      cnt_d                       = cnt_q + 2'd1;  // wraps to 0 after beat 3
    end
    valid_d = done;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      valid_q <= valid_d;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = line_q;

endmodule

// File: rtl/mem_ring_station.sv
// mem_ring_station: ring-side memory client for one processor station.
// Waits for the ring Token, then injects an Address slot (plus four WriteData
// slots for a write) and re-emits the Token. Read lines returned on the
// RDreturn/RDdest path are assembled by rd_line_assembler.
//   clock, reset                     ring clock, synchronous active-high reset
//   RingIn/SlotTypeIn/SourceIn       incoming ring slot
//   RingOut/SlotTypeOut/SourceOut    registered outgoing slot
//   RDreturn/RDdest                  read-data beats; ours when RDdest==STATION_ID
//   reqValid/reqRead/reqAddr/reqWdata  local line request
//   reqReady                         combinational accept
//   rdValid/rdData                   completed read line, one-cycle pulse
//   outstanding                      reads issued and not yet returned
//   rdError                          sticky: beat arrived with nothing outstanding
module mem_ring_station
  import ring_pkg::*;
#(
  parameter logic [3:0] STATION_ID = 4'd1,
  parameter int         MAX_OUT    = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  RingIn,
  input  logic [3:0]   SlotTypeIn,
  input  logic [3:0]   SourceIn,
  output logic [31:0]  RingOut,
  output logic [3:0]   SlotTypeOut,
  output logic [3:0]   SourceOut,
  input  logic [31:0]  RDreturn,
  input  logic [3:0]   RDdest,
  input  logic         reqValid,
  input  logic         reqRead,
  input  logic [25:0]  reqAddr,
  input  logic [127:0] reqWdata,
  output logic         reqReady,
  output logic         rdValid,
  output logic [127:0] rdData,
  output logic [3:0]   outstanding,
  output logic         rdError
);

  localparam logic [3:0] MAX_OUT_W = 4'(MAX_OUT);

  station_state_e state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [31:0]    ring_out_q, ring_out_d;
  logic [3:0]     type_out_q, type_out_d;
  logic [3:0]     src_out_q, src_out_d;
  logic [3:0]     outstanding_q, outstanding_d;
  logic           rd_error_q, rd_error_d;

  logic slot_null;
  logic transfer;
  logic issue;
  logic beat_vld;
  logic line_done;

  assign slot_null = (SlotTypeIn == SLOT_NULL);
  assign beat_vld  = (RDdest == STATION_ID);

  // A read is only eligible while a tracking slot is free; writes never wait.
  assign reqReady  = ~reset & (state_q == ST_IDLE) & (SlotTypeIn == SLOT_TOKEN) & reqValid
                   & (~reqRead | (outstanding_q < MAX_OUT_W));
  assign transfer  = reqReady;
  assign issue     = transfer & reqRead;

  // Next-state logic. The absorbed Token's slot carries the Address in the
  // transfer cycle itself, so ST_ADDR is never resident: the FSM moves
  // straight on to the write data or to Token re-emission.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d = reqRead ? ST_RETOK : ST_WDATA;
          beat_d  = 2'd0;
        end
      end
      ST_WDATA: begin
        if (slot_null) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = ST_RETOK;
        end
      end
      ST_RETOK: begin
        if (slot_null) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: forward the incoming slot unless this cycle injects.
  always_comb begin
    ring_out_d = RingIn;
    type_out_d = SlotTypeIn;
    src_out_d  = SourceIn;
    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          ring_out_d = addr_payload(reqRead, reqAddr);
          type_out_d = SLOT_ADDR;
          src_out_d  = STATION_ID;
        end
      end
      ST_WDATA: begin
        if (slot_null) begin
          ring_out_d = wdata_q[{beat_q, 5'b0} +: 32];
          type_out_d = SLOT_WDATA;
          src_out_d  = STATION_ID;
        end
      end
      ST_RETOK: begin
        if (slot_null) begin
          ring_out_d = '0;
          type_out_d = SLOT_TOKEN;
          src_out_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Only the write line needs holding; address and direction leave with the
  // Address slot in the transfer cycle.
  always_comb begin
    wdata_d = transfer ? reqWdata : wdata_q;
  end

  // Issue and completion in the same cycle cancel out. A completion with
  // nothing outstanding (stray beats) must not wrap the counter.
  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !line_done)
      outstanding_d = outstanding_q + 4'd1;
    else if (!issue && line_done && (outstanding_q != 4'd0))
      outstanding_d = outstanding_q - 4'd1;
    rd_error_d = rd_error_q | (beat_vld & (outstanding_q == 4'd0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      ring_out_q    <= '0;
      type_out_q    <= SLOT_NULL;
      src_out_q     <= '0;
      outstanding_q <= '0;
      rd_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      ring_out_q    <= ring_out_d;
      type_out_q    <= type_out_d;
      src_out_q     <= src_out_d;
      outstanding_q <= outstanding_d;
      rd_error_q    <= rd_error_d;
    end
  end

  always_ff @(posedge clock) begin
    wdata_q <= wdata_d;
  end

  rd_line_assembler u_rd_line_assembler (
    .clock     (clock),
    .reset     (reset),
    .beat_vld  (beat_vld),
    .beat_data (RDreturn),
    .done      (line_done),
    .rd_valid  (rdValid),
    .rd_data   (rdData)
  );

  assign RingOut     = ring_out_q;
  assign SlotTypeOut = type_out_q;
  assign SourceOut   = src_out_q;
  assign outstanding = outstanding_q;
  assign rdError     = rd_error_q;

endmodule

// File: doc/mem_ring_station.md
# mem_ring_station

Ring-side memory client for one processor station on the Beehive ring. It accepts line-sized read/write requests from a local requester and waits for the ring Token. It then injects an Address slot, plus four WriteData slots for writes, and re-emits the Token. It also assembles 128-bit read lines returned by the memory controller on the separate RDreturn/RDdest path. The block sits directly upstream of the coherent memory mux, between a core's cache and the ring.

## Interface
- STATION_ID, 4'd1: this station's ring ID. Nonzero; 0 is the memory controller.
- MAX_OUT, 4: maximum outstanding reads, from 1 to 15.
- clock  in  1  ring clock.
- reset  in  1  synchronous, active-high.
- RingIn / SlotTypeIn / SourceIn  in  32/4/4  incoming ring slot.
- RingOut / SlotTypeOut / SourceOut  out  32/4/4  registered outgoing slot. Reset value: 0 / 7 (Null) / 0.
- RDreturn / RDdest  in  32/4  read-data return path. A beat is ours iff RDdest == STATION_ID.
- reqValid  in  1  request pending.
- reqRead  in  1  1 = read, 0 = write.
- reqAddr  in  26  line address.
- reqWdata  in  128  write line. Word k is bits [32k+31:32k].
- reqReady  out  1  combinational. A transfer occurs when reqValid & reqReady.
- rdValid  out  1  one-cycle pulse with a complete line. No backpressure. Reset value 0.
- rdData  out  128  returned line. Reset value 0.
- outstanding  out  4  reads issued and not yet returned. Reset value 0.
- rdError  out  1  sticky. Set when a beat arrives with outstanding == 0. Reset value 0.

## Operation
- Slot types: Token=1, Address=2, WriteData=3, Null=7.
- Address payload: [28] = read flag, [25:0] = line address, all other bits 0. SourceOut = STATION_ID on every slot this block injects.
- States:
  - IDLE.
  - ADDR.
  - WDATA, with 2-bit beat counter.
  - RETOK.
- IDLE:
  - Outgoing slot = registered copy of the incoming slot.
  - reqReady = (SlotTypeIn == Token) & reqValid & (~reqRead | outstanding < MAX_OUT).
  - On transfer: latch the request, absorb the Token, go to ADDR.
  - On Token with no eligible request: pass the Token through unchanged.
- Injection rule for all sending states: the station injects only when the incoming slot is Null. Otherwise it forwards the incoming slot, stays in state, and retries next cycle.
- ADDR: inject Address. Then go to WDATA (write) or RETOK (read). A read increments outstanding at the Address injection.
- WDATA: inject WriteData with words 0,1,2,3 in order, one per accepted slot. After word 3, go to RETOK.
- RETOK: inject Token (RingOut=0, SourceOut=0). Go to IDLE.
- At most one request per Token possession.
- Read return:
  - 2-bit word counter. Beat k is written into rdData[32k+31:32k].
  - On beat 3: rdValid=1 the next cycle, outstanding decrements, counter wraps to 0.
- Simultaneous issue and return completion: outstanding is unchanged.
- Beats with outstanding == 0: set rdError. The data is still assembled.
- reset mid-burst:
  - All state returns to IDLE; outputs take their reset values.
  - The held Token is lost. Ring-wide reset regenerates it at the memory controller.

## Timing
- Request transfer at cycle t (Token on SlotTypeIn at t).
- Address appears on SlotTypeOut at t+1.
- Write with Null incoming slots: WriteData at t+2..t+5, Token at t+6.
- Read: Token at t+2.
- Each non-Null incoming slot during sending delays all later injections by 1 cycle.
- Token pass-through latency: 1 cycle.
- Read return: rdValid at 1 cycle after the 4th beat.

## Structure
- Shared package `ring_pkg`:
  - slot-type constants;
  - Address-payload field positions (READ_BIT=28, ADDR_MSB=25);
  - station-state enum.
  - The memory mux uses the same constants.
- One sub-module, `rd_line_assembler`:
  - word counter, 128-bit line register, rdValid pulse;
  - its `done` output drives the outstanding decrement.

## Test plan
- Write, clean ring:
  - Stimulus: reqAddr=26'h0000123, reqWdata words 11111111/22222222/33333333/44444444, Token at cycle 10.
  - Response: Address 32'h00000123 at 11; WriteData words at 12–15 in order; Token at 16; SourceOut=1 on all injected slots.
- Read and return:
  - Stimulus: read 26'h3FFFFFF. Then 4 beats with RDdest=1 carrying A0..A3.
  - Response: Address 32'h13FFFFFF. outstanding 0→1→0. rdValid pulse with rdData={A3,A2,A1,A0}.
- Collision:
  - Stimulus: during a write, a Message slot (type 8) arrives at cycle 12.
  - Response: the Message is forwarded at 13; WriteData words at 12, 14, 15, 16; Token at 17.
- Limit:
  - Stimulus: MAX_OUT=2, issue 2 reads, a third read pending, Token arrives.
  - Response: reqReady=0 and the Token passes through. After a return completes, the next Token is accepted.
- Simultaneous events:
  - Stimulus: a read Address is injected in the same cycle as beat 3 of an earlier read.
  - Response: outstanding is unchanged. Stray beat with outstanding=0 → rdError=1 until reset.
- Reset in WDATA:
  - Stimulus: assert reset after word 1.
  - Response: next cycle SlotTypeOut=7, RingOut=0, outstanding=0, state IDLE, reqReady=0.
